// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver: synchronizes the PS/2 clock/data pair, deframes 11-bit
// frames with odd parity and a frame timeout, then folds F0/E0 prefixes into key events.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_clk,
    input  logic       PS2_dat,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_ext,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] o_dbg_state
);
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [SYNC_N-1:0] r_clk_sync;
    logic [SYNC_N-1:0] r_dat_sync;
    logic              r_clk_prev;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_cnt_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_par_ok;
    logic              w_par_ok_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_cnt_nxt;
    logic              r_byte_stb;
    logic              w_byte_stb_nxt;
    logic              r_frame_err;
    logic              w_err_nxt;
    logic              r_brk_pending;
    logic              r_ext_pending;
    logic [7:0]        r_key_code;
    logic              r_key_valid;
    logic              r_key_release;
    logic              r_key_ext;
    logic              w_clk_s;
    logic              w_dat_s;
    logic              w_fall;

    assign w_clk_s = r_clk_sync[SYNC_N-1];
    assign w_dat_s = r_dat_sync[SYNC_N-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_N-2:0], PS2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_N-2:0], PS2_dat};
            r_clk_prev <= w_clk_s;
        end
    end

    // An edge always wins over the timeout: it restarts the counter in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_par_ok_nxt   = r_par_ok;
        w_to_cnt_nxt   = r_to_cnt;
        w_byte_stb_nxt = 1'b0;
        w_err_nxt      = 1'b0;
        if (w_fall) begin
            w_to_cnt_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (!w_dat_s) begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end
                end
                S_DATA: begin
                    w_shift_nxt = {w_dat_s, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt   = S_PARITY;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
                S_PARITY: begin
                    w_par_ok_nxt = (^r_shift) ^ w_dat_s;
                    w_state_nxt  = S_STOP;
                end
                S_STOP: begin
                    if (w_dat_s && r_par_ok) begin
                        w_byte_stb_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (r_to_cnt == TO_LAST) begin
                w_state_nxt   = S_IDLE;
                w_bit_cnt_nxt = 3'd0;
                w_to_cnt_nxt  = '0;
                w_err_nxt     = 1'b1;
            end else begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_par_ok    <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_stb  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par_ok    <= w_par_ok_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_byte_stb  <= w_byte_stb_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    // r_shift is stable here: the next frame's start bit does not shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_brk_pending <= 1'b0;
            r_ext_pending <= 1'b0;
            r_key_code    <= 8'h00;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_ext     <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_frame_err) begin
                r_brk_pending <= 1'b0;
                r_ext_pending <= 1'b0;
            end else if (r_byte_stb) begin
                if (r_shift == 8'hF0) begin
                    r_brk_pending <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                    r_ext_pending <= 1'b1;
                end else begin
                    r_key_valid   <= 1'b1;
                    r_key_code    <= r_shift;
                    r_key_release <= r_brk_pending;
                    r_key_ext     <= r_ext_pending;
                    r_brk_pending <= 1'b0;
                    r_ext_pending <= 1'b0;
                end
            end
        end
    end

    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_release = r_key_release;
    assign key_ext     = r_key_ext;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;
endmodule
